// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, pipeline/response structs and store/alignment helpers
// shared by the load/store unit and its load-formatting sub-module.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Tag width carried in the structs; the lsu TAG_W parameter defaults to it.
    localparam int LSU_TAG_W = 5;

    // Request metadata registered in stage s1.
    typedef struct packed {
        logic [1:0]           size;
        logic [1:0]           offset;
        logic                 unsgn;
        logic [LSU_TAG_W-1:0] tag;
        logic                 we;
        logic                 err;
    } lsu_meta_t;

    // Formatted response, as presented to the core or parked in the hold buffer.
    typedef struct packed {
        logic [31:0]          data;
        logic [LSU_TAG_W-1:0] tag;
        logic                 we;
        logic                 err;
    } lsu_rsp_t;

    // Byte offset truncated to the natural alignment of the access size.
    function automatic logic [1:0] lsu_eff_offset(input logic [1:0] size,
                                                   input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return addr_lo;
            SZ_H:    return {addr_lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    // Byte write enables for a store at an (already aligned) offset.
    function automatic logic [3:0] lsu_wmask(input logic [1:0] size,
                                             input logic [1:0] offset);
        case (size)
            SZ_B:    return 4'b0001 << offset;
            SZ_H:    return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store data across all lanes so the mask alone picks bytes.
    function automatic logic [31:0] lsu_replicate(input logic [1:0]  size,
                                                  input logic [31:0] wdata);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

    // True when the address is not naturally aligned for the size.
    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed lane out of a memory word and sign- or
// zero-extends it. Purely combinational; reused by the port-b instance.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        unsgn,
    input  logic [31:0] data,
    output logic [31:0] result
);

    logic [7:0]  lane8;
    logic [15:0] lane16;

    // Lane select by offset, then extension by size.
    always_comb begin
        lane8  = 8'h00;
        lane16 = offset[1] ? data[31:16] : data[15:0];
        case (offset)
            2'd0: lane8 = data[7:0];
            2'd1: lane8 = data[15:8];
            2'd2: lane8 = data[23:16];
            default: lane8 = data[31:24];
        endcase
        case (size)
            SZ_B:    result = {{24{!unsgn & lane8[7]}}, lane8};
            SZ_H:    result = {{16{!unsgn & lane16[15]}}, lane16};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit driving one data-memory port. Requests drive the memory
// combinationally in the accept cycle, the registered read data is formatted in
// s1, and a one-entry hold buffer absorbs a single cycle of response back-pressure.
// Optional macro LSU_ALIGN_CHECK_EN: flag misaligned half/word accesses as errors
// (no write, zero data); otherwise offsets are silently truncated.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = LSU_TAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_we,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    output logic              mem_cen,
    input  logic [31:0]       mem_data
);

    logic      s1_valid_q, s1_valid_d;
    lsu_meta_t s1_meta_q, s1_meta_d;
    logic      hold_valid_q, hold_valid_d;
    lsu_rsp_t  hold_q, hold_d;

    logic       accept;
    logic       req_err;
    logic [1:0] req_off;
    logic [31:0] s1_load;
    lsu_rsp_t   s1_rsp;
    lsu_rsp_t   rsp_sel;

`ifdef LSU_ALIGN_CHECK_EN
    assign req_err = lsu_misaligned(req_size, req_addr[1:0]);
`else
    assign req_err = 1'b0;
`endif

    assign req_off   = lsu_eff_offset(req_size, req_addr[1:0]);
    // Stall when a response is parked, or when s1 is about to be parked now.
    assign req_ready = !reset && !hold_valid_q && !(s1_valid_q && !rsp_ready);
    assign accept    = req_valid && req_ready;

    // Memory port drive; everything is zero unless a request is accepted.
    always_comb begin
        mem_cen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        mem_wmask = 4'b0000;
        if (accept) begin
            mem_cen   = 1'b1;
            mem_addr  = {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata = lsu_replicate(req_size, req_wdata);
            if (req_we && !req_err) mem_wmask = lsu_wmask(req_size, req_off);
        end
    end

    // Stage s1 captures request metadata alongside the memory read.
    always_comb begin
        s1_valid_d = accept;
        s1_meta_d  = s1_meta_q;
        if (accept) begin
            s1_meta_d.size   = req_size;
            s1_meta_d.offset = req_off;
            s1_meta_d.unsgn  = req_unsigned;
            s1_meta_d.tag    = LSU_TAG_W'(req_tag);
            s1_meta_d.we     = req_we;
            s1_meta_d.err    = req_err;
        end
    end

    lsu_load_align u_align (
        .size   (s1_meta_q.size),
        .offset (s1_meta_q.offset),
        .unsgn  (s1_meta_q.unsgn),
        .data   (mem_data),
        .result (s1_load)
    );

    // Format the s1 response; stores and errors return zero data.
    always_comb begin
        s1_rsp.data = (s1_meta_q.we || s1_meta_q.err) ? 32'h0 : s1_load;
        s1_rsp.tag  = s1_meta_q.tag;
        s1_rsp.we   = s1_meta_q.we;
        s1_rsp.err  = s1_meta_q.err;
    end

    // Hold buffer: park s1 when the core refuses it, release on acceptance.
    // s1 is always empty while hold is full because req_ready is low then.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_d       = hold_q;
        if (hold_valid_q) begin
            if (rsp_ready) hold_valid_d = 1'b0;
        end else if (s1_valid_q && !rsp_ready) begin
            hold_valid_d = 1'b1;
            hold_d       = s1_rsp;
        end
    end

    // Response mux; payload is forced to zero when no response is presented.
    always_comb begin
        rsp_valid = !reset && (hold_valid_q || s1_valid_q);
        rsp_sel   = hold_valid_q ? hold_q : s1_rsp;
        if (!rsp_valid) rsp_sel = '0;
        rsp_data  = rsp_sel.data;
        rsp_tag   = TAG_W'(rsp_sel.tag);
        rsp_we    = rsp_sel.we;
        rsp_err   = rsp_sel.err;
    end

    // State registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_meta_q    <= '0;
            hold_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_meta_q    <= s1_meta_d;
            hold_valid_q <= hold_valid_d;
            hold_q       <= hold_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a behavioural registered-read RAM and an
// in-order scoreboard of expected responses.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_tag;
    logic        rsp_valid, rsp_ready, rsp_we, rsp_err;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_tag;
    logic [31:0] mem_addr, mem_wdata, mem_data;
    logic [3:0]  mem_wmask;
    logic        mem_cen;

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32), .TAG_W(5)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_we(rsp_we), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
        .mem_cen(mem_cen), .mem_data(mem_data)
    );

    // Data memory: byte-masked write, registered read of the old contents.
    logic [31:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_cen) begin
            for (int i = 0; i < 4; i++)
                if (mem_wmask[i]) ram[mem_addr[9:2]][i*8 +: 8] <= mem_wdata[i*8 +: 8];
            mem_data <= ram[mem_addr[9:2]];
        end
    end

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  t;
        logic        we;
        logic        err;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    logic        s_ready, s_valid, s_cen;
    logic [3:0]  s_wmask;
    logic [31:0] s_addr, s_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare a presented-and-accepted response against the scoreboard head.
    task automatic check_rsp();
        exp_t e;
        exp_t got;
        got = '{d: rsp_data, t: rsp_tag, we: rsp_we, err: rsp_err};
        if (rsp_valid && rsp_ready) begin
            checks++;
            assert (q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_rsp observed=%h expected=none", got);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                assert (got === e) else begin
                    failures++;
                    $error("FAIL rsp_tag%0d observed=%h expected=%h", e.t, got, e);
                end
            end
        end else if (!rsp_valid) begin
            checks++;
            assert (got === '0) else begin
                failures++;
                $error("FAIL rsp_idle_zero observed=%h expected=0", got);
            end
        end
    endtask

    task automatic neg_sample();
        @(negedge clk);
        s_ready = req_ready; s_valid = rsp_valid; s_cen = mem_cen;
        s_wmask = mem_wmask; s_addr = mem_addr; s_wdata = mem_wdata;
        check_rsp();
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    // Present one request until accepted; s_* then hold the accept-cycle memory drive.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] tag,
                         input logic [31:0] exp_d, input logic exp_err, input bit push);
        bit acc;
        acc = 0;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_tag = tag;
        if (push) q.push_back('{d: exp_d, t: tag, we: we, err: exp_err});
        for (int n = 0; n < 20 && !acc; n++) begin
            neg_sample();
            acc = s_ready;
            post();
        end
        req_valid = 1'b0;
        chk($sformatf("accept_tag%0d", tag), 32'(acc), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 30 && q.size() != 0; n++) begin
            neg_sample();
            post();
        end
        chk("drain_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        reset = 1'b1; rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_unsigned = 1'b0;
        req_addr = 32'h104; req_wdata = 32'hFFFF_FFFF; req_tag = 5'd3;
        post();
        // Reset: every output reads zero even with a request pending.
        neg_sample();
        chk("rst_req_ready", 32'(s_ready), 0);
        chk("rst_rsp_valid", 32'(s_valid), 0);
        chk("rst_mem_cen", 32'(s_cen), 0);
        chk("rst_mem_wmask", 32'(s_wmask), 0);
        chk("rst_mem_addr", s_addr, 0);
        chk("rst_mem_wdata", s_wdata, 0);
        post();
        reset = 1'b0; req_valid = 1'b0;
        post();

        // Word store then word load, load response one cycle after accept.
        issue(1, SZ_W, 0, 32'h100, 32'hDEAD_BEEF, 5'd1, 32'h0, 0, 1);
        chk("sw_wmask", 32'(s_wmask), 32'hF);
        chk("sw_addr", s_addr, 32'h100);
        chk("sw_wdata", s_wdata, 32'hDEAD_BEEF);
        chk("sw_cen", 32'(s_cen), 1);
        issue(0, SZ_W, 0, 32'h100, 32'h0, 5'd2, 32'hDEAD_BEEF, 0, 1);
        chk("lw_wmask", 32'(s_wmask), 0);
        neg_sample();
        chk("lw_latency", 32'(s_valid), 1);
        post();

        // Sub-word loads on 0x80FF7F01, back to back.
        issue(1, SZ_W, 0, 32'h300, 32'h80FF_7F01, 5'd3, 32'h0, 0, 1);
        issue(0, SZ_B, 0, 32'h303, 32'h0, 5'd4, 32'hFFFF_FF80, 0, 1);
        issue(0, SZ_B, 1, 32'h303, 32'h0, 5'd5, 32'h0000_0080, 0, 1);
        issue(0, SZ_H, 0, 32'h302, 32'h0, 5'd6, 32'hFFFF_80FF, 0, 1);
        issue(0, SZ_H, 1, 32'h302, 32'h0, 5'd7, 32'h0000_80FF, 0, 1);
        issue(0, SZ_B, 0, 32'h301, 32'h0, 5'd8, 32'h0000_007F, 0, 1);
        issue(0, SZ_H, 0, 32'h300, 32'h0, 5'd9, 32'h0000_7F01, 0, 1);
        drain();

        // Byte and half stores only touch their lanes.
        issue(1, SZ_W, 0, 32'h200, 32'h1122_3344, 5'd10, 32'h0, 0, 1);
        issue(1, SZ_B, 0, 32'h201, 32'hFFFF_FFA5, 5'd11, 32'h0, 0, 1);
        chk("sb_wmask", 32'(s_wmask), 32'h2);
        chk("sb_wdata", s_wdata, 32'hA5A5_A5A5);
        chk("sb_addr", s_addr, 32'h200);
        issue(0, SZ_W, 0, 32'h200, 32'h0, 5'd12, 32'h1122_A544, 0, 1);
        issue(1, SZ_H, 0, 32'h202, 32'h0000_BEEF, 5'd13, 32'h0, 0, 1);
        chk("sh_wmask", 32'(s_wmask), 32'hC);
        chk("sh_wdata", s_wdata, 32'hBEEF_BEEF);
        issue(0, SZ_W, 0, 32'h200, 32'h0, 5'd14, 32'hBEEF_A544, 0, 1);
        drain();

        // Misaligned word store / half load.
`ifdef LSU_ALIGN_CHECK_EN
        issue(1, SZ_W, 0, 32'h202, 32'h5566_7788, 5'd15, 32'h0, 1, 1);
        chk("mis_sw_wmask", 32'(s_wmask), 0);
        issue(0, SZ_W, 0, 32'h200, 32'h0, 5'd16, 32'hBEEF_A544, 0, 1);
        issue(0, SZ_H, 0, 32'h201, 32'h0, 5'd17, 32'h0, 1, 1);
`else
        issue(1, SZ_W, 0, 32'h202, 32'h5566_7788, 5'd15, 32'h0, 0, 1);
        chk("mis_sw_wmask", 32'(s_wmask), 32'hF);
        chk("mis_sw_addr", s_addr, 32'h200);
        issue(0, SZ_W, 0, 32'h200, 32'h0, 5'd16, 32'h5566_7788, 0, 1);
        issue(0, SZ_H, 0, 32'h201, 32'h0, 5'd17, 32'h0000_7788, 0, 1);
`endif
        drain();

        // Back-pressure: rsp_ready low for 3 cycles after the second load.
        issue(0, SZ_W, 0, 32'h300, 32'h0, 5'd0, 32'h80FF_7F01, 0, 1);
        issue(0, SZ_B, 0, 32'h300, 32'h0, 5'd1, 32'h0000_0001, 0, 1);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_B; req_unsigned = 1'b1;
        req_addr = 32'h303; req_tag = 5'd2;
        for (int n = 0; n < 3; n++) begin
            neg_sample();
            chk("stall_req_ready", 32'(s_ready), 0);
            chk("stall_rsp_valid", 32'(s_valid), 1);
            chk("stall_rsp_tag", 32'(rsp_tag), 32'd1);
            chk("stall_rsp_data", rsp_data, 32'h0000_0001);
            post();
        end
        rsp_ready = 1'b1;
        issue(0, SZ_B, 1, 32'h303, 32'h0, 5'd2, 32'h0000_0080, 0, 1);
        issue(0, SZ_W, 0, 32'h100, 32'h0, 5'd3, 32'hDEAD_BEEF, 0, 1);
        drain();

        // Reset right after a load accept: load dropped, store during reset ignored.
        issue(0, SZ_W, 0, 32'h300, 32'h0, 5'd20, 32'h0, 0, 0);
        reset = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_W; req_addr = 32'h100;
        req_wdata = 32'h0; req_tag = 5'd22;
        neg_sample();
        chk("mid_rst_rsp_valid", 32'(s_valid), 0);
        chk("mid_rst_req_ready", 32'(s_ready), 0);
        chk("mid_rst_mem_cen", 32'(s_cen), 0);
        chk("mid_rst_mem_wmask", 32'(s_wmask), 0);
        chk("mid_rst_mem_addr", s_addr, 0);
        chk("mid_rst_mem_wdata", s_wdata, 0);
        post();
        reset = 1'b0; req_valid = 1'b0;
        neg_sample();
        chk("post_rst_rsp_valid", 32'(s_valid), 0);
        post();
        issue(0, SZ_W, 0, 32'h100, 32'h0, 5'd21, 32'hDEAD_BEEF, 0, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit that acts as the initiator on one data-memory port. It accepts byte, half and word load/store requests from the core pipeline and drives address, byte write mask, write data and clock enable toward the dual-port data memory. It captures the memory's registered read data one cycle later and returns an aligned, sign- or zero-extended response to the core. One instance serves each memory port (a or b).

## Interface
Parameters:
- `ADDR_W`, 32: request and memory address width.
- `TAG_W`, 5: destination-register tag width, echoed on the response.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: core request valid.
- `req_ready` out 1: unit can accept this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: `SZ_B`, `SZ_H`, `SZ_W`.
- `req_unsigned` in 1: zero-extend the load (LBU/LHU).
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, LSB-justified.
- `req_tag` in TAG_W: destination tag.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: core accepts the response.
- `rsp_data` out 32: extended load data; 0 for stores and errors.
- `rsp_tag` out TAG_W: echoed tag.
- `rsp_we` out 1: response belongs to a store.
- `rsp_err` out 1: misaligned access.
- `mem_addr` out 32: word address with bits [1:0] = 0.
- `mem_wmask` out 4: byte write enables.
- `mem_wdata` out 32: lane-replicated store data.
- `mem_cen` out 1: memory clock enable.
- `mem_data` in 32: registered read data, valid 1 cycle after `mem_cen`.

## Operation
- Accept: a request is accepted when `req_valid && req_ready`.
- Memory drive in the accept cycle (combinational from the request):
  - `mem_cen` = 1.
  - `mem_addr` = `{req_addr[31:2],2'b00}`.
  - `mem_wdata`: byte store replicates the byte ×4; half store replicates ×2; word store passes through.
  - `mem_wmask` for stores: byte → `4'b0001 << addr[1:0]`; half → `4'b0011 << {addr[1],1'b0}`; word → `4'b1111`.
  - `mem_wmask` = 0 for loads, for errors, and in any cycle with no acceptance.
- Stage s1: registers valid, size, offset, unsigned, tag, we and err at acceptance.
- Load formatting from `mem_data` in s1:
  - Select the lane by offset.
  - Sign-extend unless unsigned. Word loads pass through.
- Hold buffer: one entry. If s1 is valid and `rsp_ready`=0, the formatted s1 result moves into the hold buffer and `hold_valid` is set.
- Response selection:
  - The response comes from the hold buffer when `hold_valid`, otherwise from s1.
  - `rsp_valid` = `hold_valid | s1_valid`.
  - `hold_valid` clears when its response is accepted.
- Ready: `req_ready` = `!reset && !hold_valid && !(s1_valid && !rsp_ready)`.
- Ordering: responses are in strict request order. Every request produces exactly one response, including stores.
- Reset: clears s1 and hold valids. All outputs read 0: `rsp_valid`, `rsp_data`, `rsp_tag`, `rsp_we`, `rsp_err`, `req_ready`, `mem_cen`, `mem_wmask`, `mem_addr`, `mem_wdata`.
- Reset mid-operation: in-flight loads are dropped without a response. A store's memory write happens only if it was accepted before reset rose.

## Timing
- Load latency: accept at cycle N, `rsp_valid` at N+1 when `rsp_ready` is high.
- Throughput: one request per cycle while `rsp_ready`=1.
- `rsp_ready` falling with s1 valid: the result moves to hold at that edge and no request is accepted that cycle. The held response stays stable until accepted.
- `rsp_data`, `rsp_tag`, `rsp_we` and `rsp_err` are 0 whenever `rsp_valid`=0.
- `req_ready` depends combinationally on `rsp_ready`. `rsp_*` is never combinational from `req_*`.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - Half at odd address, or word with addr[1:0]≠0, is an error.
  - An error forces `mem_wmask`=0, sets `rsp_err`=1 and gives `rsp_data`=0.
- `LSU_ALIGN_CHECK_EN` undefined:
  - No check. Offset bits are silently truncated to the natural alignment of the size.
  - `rsp_err` is tied to 0.

## Structure
- `lsu_pkg`:
  - Size encoding: `SZ_B`=2'b00, `SZ_H`=2'b01, `SZ_W`=2'b10.
  - `lsu_meta_t` struct: size, offset, unsigned, tag, we, err.
  - Mask/replication helper functions.
- Sub-module `lsu_load_align`: combinational lane select plus extension, shared with the port-b instance.

## Test plan
- Word load at 0x100 with RAM[0x40]=0xDEADBEEF → `rsp_data`=0xDEADBEEF at N+1, `mem_wmask`=0.
- LB at 0x103 on 0x80FF7F01 → `rsp_data`=0xFFFFFF80. LBU → 0x00000080. LH at 0x102 → 0xFFFF80FF.
- SB 0xA5 at 0x201 → `mem_wmask`=4'b0010, `mem_wdata`=0xA5A5A5A5. Read-back word shows only byte 1 changed.
- Back-to-back 4 loads with `rsp_ready` low for 3 cycles after the second → tags returned in order 0,1,2,3, none lost, `req_ready`=0 during the stall.
- With `LSU_ALIGN_CHECK_EN`: SW at 0x202 → `rsp_err`=1, `mem_wmask`=0, memory unchanged. Without it: the write goes to 0x200.
- Reset asserted the cycle after a load is accepted → no response, all outputs 0 the next cycle, a new request is accepted after reset falls.
